fetch_stage: RTL
================

# fetch_stage

Fetch stage of the five-stage MIPS pipeline. It holds the architectural fetch PC (F_PC) and drives the instruction-memory read address. Each cycle it loads the next PC computed by the downstream next-PC logic. It also owns the F/D pipeline register, which captures the fetched instruction, its PC, a valid bit and an address-error flag for the decode stage, under hazard-unit stall and flush control.

## Interface
Parameters:
- PC_RESET, 32'h0000_3000, value loaded into F_PC on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_AW, 12, instruction-memory word-address width (2^IM_AW words).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit stall; holds F_PC and the F/D register.
- flush  in  1  replaces the F/D contents with a bubble on this edge.
- NPC  in  32  next PC from the next-PC logic, combinationally derived from F_PC and decode-stage state.
- F_PC  out  32  current fetch PC; fed back to the next-PC logic.
- im_addr  out  IM_AW  word address to instruction memory, which is a combinational read.
- im_rdata  in  32  instruction word at im_addr, same cycle.
- D_IR  out  32  decode-stage instruction.
- D_PC  out  32  decode-stage instruction PC.
- D_PC8  out  32  D_PC + 8, the link value for jal/jalr.
- D_valid  out  1  D holds a real fetched instruction, not a bubble.
- D_AdEL  out  1  D's fetch was misaligned or outside instruction memory.
- fetch_count  out  32  number of valid instructions loaded into D.

## Operation
- fetch_ok = (F_PC[1:0] == 0) && (F_PC >= IM_BASE) && (F_PC < IM_BASE + 4*2^IM_AW).
  - Compute the comparison in 33 bits so that the top of the 32-bit space does not wrap.
- im_addr = (F_PC − IM_BASE)[IM_AW+1:2]. The value is don't-care when fetch_ok = 0.
- PC register:
  - stall = 1: F_PC holds.
  - stall = 0: F_PC ← NPC. Alignment is not checked on load; a bad NPC is flagged when it reaches D.
- F/D register, evaluated in priority order:
  1. flush = 1 (regardless of stall): D_IR ← 0, D_PC ← 0, D_valid ← 0, D_AdEL ← 0.
  2. Otherwise stall = 1: all D fields hold.
  3. Otherwise: D_PC ← F_PC, D_valid ← 1, D_AdEL ← !fetch_ok, and D_IR ← fetch_ok ? im_rdata : 32'h0000_0000. D_IR = 0 is a nop.
- flush and stall both 1: F_PC holds and D is cleared, so the held F_PC instruction is re-fetched when the stall releases.
- D_PC8 = D_PC + 8, combinational, modulo 2^32.
- fetch_count increments by 1 on every case-3 load with fetch_ok = 1. It holds otherwise and wraps from 32'hFFFF_FFFF to 0.
- Branch delay slots need no special handling: the instruction after a branch is fetched normally. flush exists for the exception and eret path only.

## Timing
- Reset (asynchronous, takes effect immediately):
  - F_PC = PC_RESET.
  - D_IR = 0, D_PC = 0, D_valid = 0, D_AdEL = 0, fetch_count = 0.
  - D_PC8 = 8 as a consequence.
- First edge after reset deassertion with no stall/flush: D_PC = PC_RESET, D_valid = 1, and F_PC = NPC (normally PC_RESET + 4).
- Latency: an instruction at F_PC appears in D one edge later, absent stall.
- Combinational paths: F_PC→im_addr, im_rdata→D_IR input, and F_PC→NPC→F_PC input. There is no combinational path from stall or flush to any output.
- Reset asserted mid-stall or mid-flush overrides both; no state survives.

## Test plan
- Reset then 3 free-running edges with NPC = F_PC + 4 and IM word k = 32'h1000_0000 + k → D_PC goes 3000, 3004, 3008; D_IR goes 1000_0000, 1000_0001, 1000_0002; fetch_count = 3; D_PC8 = 3010 at the end.
- stall = 1 for 2 edges with F_PC = 3008 → F_PC, D_PC and fetch_count are unchanged. On release, D_PC = 3008.
- flush = 1 and stall = 1 together with D_PC = 3004 and F_PC = 3008 → D_valid = 0, D_IR = 0, D_PC = 0, F_PC = 3008, fetch_count unchanged. Next free edge gives D_PC = 3008.
- Fetch-error cases, each loaded via NPC:
  - NPC = 3002 → next cycle D_AdEL = 1, D_IR = 0, D_valid = 1, fetch_count not incremented.
  - NPC = 2FFC (below IM_BASE) → D_AdEL = 1.
  - NPC = 7000 (first address past the default memory top) → D_AdEL = 1.
- Jump: NPC = 0000_3400 → im_addr = 0x100 the next cycle, and D_PC = 3400 one edge after that.
- Counter wrap: force fetch_count to FFFF_FFFF, then do one valid load → fetch_count = 0. Assert reset asynchronously between edges → all outputs take their reset values immediately.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard controls, next-PC feedback, instruction-memory port
// and the F/D pipeline outputs seen by decode.
interface fetch_stage_if #(
  parameter int IM_AW = 12
);
  logic             stall;
  logic             flush;
  logic [31:0]      NPC;
  logic [31:0]      F_PC;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      D_IR;
  logic [31:0]      D_PC;
  logic [31:0]      D_PC8;
  logic             D_valid;
  logic             D_AdEL;
  logic [31:0]      fetch_count;

  modport master (
    output stall, flush, NPC, im_rdata,
    input  F_PC, im_addr, D_IR, D_PC, D_PC8, D_valid, D_AdEL, fetch_count
  );

  modport slave (
    input  stall, flush, NPC, im_rdata,
    output F_PC, im_addr, D_IR, D_PC, D_PC8, D_valid, D_AdEL, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS fetch stage: fetch PC register, instruction-memory addressing and the
// F/D pipeline register with stall/flush control and a valid-fetch counter.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  logic [31:0] pc_r;
  logic [31:0] d_ir_r;
  logic [31:0] d_pc_r;
  logic        d_valid_r;
  logic        d_adel_r;
  logic [31:0] fetch_count_r;

  logic [32:0] pc_ext_s;
  logic [32:0] base_ext_s;
  logic [32:0] top_ext_s;
  logic [31:0] offset_s;
  logic        fetch_ok_s;
  logic        load_s;
  logic [31:0] fetch_ir_s;

  // Range check in 33 bits so a memory ending at the top of the space does not wrap.
  always_comb begin
    pc_ext_s   = {1'b0, pc_r};
    base_ext_s = {1'b0, IM_BASE};
    top_ext_s  = base_ext_s + (33'd4 << IM_AW);
    offset_s   = pc_r - IM_BASE;
    fetch_ok_s = (pc_r[1:0] == 2'b00) && (pc_ext_s >= base_ext_s) && (pc_ext_s < top_ext_s);
    load_s     = !bus.flush && !bus.stall;
    if (fetch_ok_s) begin
      fetch_ir_s = bus.im_rdata;
    end else begin
      fetch_ir_s = 32'h0000_0000;
    end
  end

  // Fetch PC: follows NPC unless stalled; alignment is judged once it reaches D.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= PC_RESET;
    end else if (!bus.stall) begin
      pc_r <= bus.NPC;
    end else begin
      pc_r <= pc_r;
    end
  end

  // F/D register: flush beats stall, so a stalled+flushed slot re-fetches on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_ir_r    <= 32'h0000_0000;
      d_pc_r    <= 32'h0000_0000;
      d_valid_r <= 1'b0;
      d_adel_r  <= 1'b0;
    end else if (bus.flush) begin
      d_ir_r    <= 32'h0000_0000;
      d_pc_r    <= 32'h0000_0000;
      d_valid_r <= 1'b0;
      d_adel_r  <= 1'b0;
    end else if (!bus.stall) begin
      d_ir_r    <= fetch_ir_s;
      d_pc_r    <= pc_r;
      d_valid_r <= 1'b1;
      d_adel_r  <= !fetch_ok_s;
    end else begin
      d_ir_r    <= d_ir_r;
      d_pc_r    <= d_pc_r;
      d_valid_r <= d_valid_r;
      d_adel_r  <= d_adel_r;
    end
  end

  // Count only good fetches that actually enter D; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count_r <= 32'h0000_0000;
    end else if (load_s && fetch_ok_s) begin
      fetch_count_r <= fetch_count_r + 32'd1;
    end else begin
      fetch_count_r <= fetch_count_r;
    end
  end

  assign bus.F_PC        = pc_r;
  assign bus.im_addr     = IM_AW'(offset_s >> 2);
  assign bus.D_IR        = d_ir_r;
  assign bus.D_PC        = d_pc_r;
  assign bus.D_PC8       = d_pc_r + 32'd8;
  assign bus.D_valid     = d_valid_r;
  assign bus.D_AdEL      = d_adel_r;
  assign bus.fetch_count = fetch_count_r;

endmodule
